// File: rtl/flop_arb_pkg.sv
// rtl/flop_arb_pkg.sv - shared types and default sizes for the flipflop load arbiter
package flop_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        OWN  = 1'b1
    } arb_state_t;

    localparam int ARB_N_REQ    = 4;
    localparam int ARB_WIDTH    = 8;
    localparam int ARB_MAX_HOLD = 4;

endpackage

// File: rtl/rr_priority_pick.sv
// rtl/rr_priority_pick.sv - round-robin winner selection starting after the last owner
module rr_priority_pick #(
    parameter int N_REQ = 4,
    parameter int IW    = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [IW-1:0]    last,
    output logic [N_REQ-1:0] win,
    output logic [IW-1:0]    win_idx,
    output logic             any
);

    int idx;

    // Scan from last+1 around the ring; the first active request wins.
    always_comb begin
        win     = '0;
        win_idx = '0;
        any     = 1'b0;
        idx     = 0;
        for (int i = 1; i <= N_REQ; i++) begin
            idx = (int'(last) + i) % N_REQ;
            if (!any && req[idx]) begin
                any      = 1'b1;
                win[idx] = 1'b1;
                win_idx  = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/flop_load_arbiter.sv
// rtl/flop_load_arbiter.sv - round-robin owner arbitration feeding the flipflop qin register
module flop_load_arbiter
    import flop_arb_pkg::*;
#(
    parameter int N_REQ    = ARB_N_REQ,
    parameter int WIDTH    = ARB_WIDTH,
    parameter int MAX_HOLD = ARB_MAX_HOLD
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_REQ-1:0]            req,
    input  logic [N_REQ-1:0]            lock,
    input  logic [N_REQ-1:0][WIDTH-1:0] data,
    input  logic [WIDTH-1:0]            qout,
    output logic [N_REQ-1:0]            gnt,
    output logic [WIDTH-1:0]            qin,
    output logic                        wr_strobe,
    output logic                        busy,
    output logic [$clog2(N_REQ)-1:0]    owner,
    output logic [WIDTH-1:0]            rd_data
);

    localparam int IW = $clog2(N_REQ);

    arb_state_t        state;
    logic [IW-1:0]     last;
    logic [3:0]        beat;
    logic [N_REQ-1:0]  pick_win;
    logic [IW-1:0]     pick_idx;
    logic              pick_any;

    rr_priority_pick #(
        .N_REQ (N_REQ),
        .IW    (IW)
    ) u_pick (
        .req     (req),
        .last    (last),
        .win     (pick_win),
        .win_idx (pick_idx),
        .any     (pick_any)
    );

    // The register value is read straight through; no state involved.
    assign rd_data = qout;

    // Ownership FSM: grant in IDLE, accept beats in OWN, always return via IDLE.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            gnt       <= '0;
            qin       <= '0;
            wr_strobe <= 1'b0;
            busy      <= 1'b0;
            owner     <= '0;
            last      <= IW'(N_REQ - 1);
            beat      <= '0;
        end else begin
            wr_strobe <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        gnt   <= pick_win;
                        owner <= pick_idx;
                        busy  <= 1'b1;
                        beat  <= '0;
                        state <= OWN;
                    end else begin
                        gnt <= '0;
                    end
                end
                OWN: begin
                    if (req[owner] && gnt[owner]) begin
                        qin       <= data[owner];
                        wr_strobe <= 1'b1;
                        beat      <= beat + 4'd1;
                        if (!lock[owner] || (beat + 4'd1) == 4'(MAX_HOLD)) begin
                            gnt   <= '0;
                            busy  <= 1'b0;
                            last  <= owner;
                            state <= IDLE;
                        end
                    end else if (!req[owner]) begin
                        // Owner withdrew before its beat: release without writing.
                        gnt   <= '0;
                        busy  <= 1'b0;
                        last  <= owner;
                        state <= IDLE;
                    end
                end
                default: begin
                    gnt   <= '0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_flop_load_arbiter.sv
// tb/tb_flop_load_arbiter.sv - directed table and sequence checks for flop_load_arbiter
module tb_flop_load_arbiter;

    logic             clk = 1'b0;
    logic             reset;
    logic [3:0]       req;
    logic [3:0]       lock;
    logic [3:0][7:0]  data;
    logic [7:0]       qout;
    logic [3:0]       gnt;
    logic [7:0]       qin;
    logic             wr_strobe;
    logic             busy;
    logic [1:0]       owner;
    logic [7:0]       rd_data;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic       rst;
        logic [3:0] req;
        logic [3:0] lock;
        logic [7:0] d0, d1, d2, d3;
        logic [3:0] gnt;
        logic [1:0] own;
        logic       busy;
        logic       wr;
        logic [7:0] qin;
        logic [7:0] rd;
    } vec_t;

    vec_t vt [15];

    flop_load_arbiter #(
        .N_REQ    (4),
        .WIDTH    (8),
        .MAX_HOLD (4)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .lock      (lock),
        .data      (data),
        .qout      (qout),
        .gnt       (gnt),
        .qin       (qin),
        .wr_strobe (wr_strobe),
        .busy      (busy),
        .owner     (owner),
        .rd_data   (rd_data)
    );

    always #5 clk = ~clk;

    // Stand-in for the flipflop instance the arbiter drives.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) qout <= 8'h00;
        else       qout <= qin;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc(input string tag, input logic [3:0] e_gnt, input logic e_busy,
                       input logic e_wr, input logic [7:0] e_qin);
        @(posedge clk);
        #1;
        chk({tag, "_gnt"},  32'(gnt),       32'(e_gnt));
        chk({tag, "_busy"}, 32'(busy),      32'(e_busy));
        chk({tag, "_wr"},   32'(wr_strobe), 32'(e_wr));
        chk({tag, "_qin"},  32'(qin),       32'(e_qin));
    endtask

    task automatic pulse_reset();
        reset = 1'b1;
        #2;
        chk("rst_gnt",  32'(gnt),       32'h0);
        chk("rst_qin",  32'(qin),       32'h0);
        chk("rst_busy", 32'(busy),      32'h0);
        chk("rst_wr",   32'(wr_strobe), 32'h0);
        chk("rst_own",  32'(owner),     32'h0);
        reset = 1'b0;
    endtask

    initial begin
        // rst req   lock  d0     d1     d2     d3     gnt    own   busy  wr    qin    rd
        vt[0]  = '{1'b0, 4'h1, 4'h0, 8'h3C, 8'h00, 8'h00, 8'h00, 4'h1, 2'd0, 1'b1, 1'b0, 8'h00, 8'h00};
        vt[1]  = '{1'b0, 4'h1, 4'h0, 8'h3C, 8'h00, 8'h00, 8'h00, 4'h0, 2'd0, 1'b0, 1'b1, 8'h3C, 8'h00};
        vt[2]  = '{1'b0, 4'h0, 4'h0, 8'h3C, 8'h00, 8'h00, 8'h00, 4'h0, 2'd0, 1'b0, 1'b0, 8'h3C, 8'h3C};
        vt[3]  = '{1'b1, 4'hF, 4'h0, 8'h11, 8'h22, 8'h33, 8'h44, 4'h1, 2'd0, 1'b1, 1'b0, 8'h00, 8'h00};
        vt[4]  = '{1'b0, 4'hF, 4'h0, 8'h11, 8'h22, 8'h33, 8'h44, 4'h0, 2'd0, 1'b0, 1'b1, 8'h11, 8'h00};
        vt[5]  = '{1'b0, 4'hF, 4'h0, 8'h11, 8'h22, 8'h33, 8'h44, 4'h2, 2'd1, 1'b1, 1'b0, 8'h11, 8'h11};
        vt[6]  = '{1'b0, 4'hF, 4'h0, 8'h11, 8'h22, 8'h33, 8'h44, 4'h0, 2'd1, 1'b0, 1'b1, 8'h22, 8'h11};
        vt[7]  = '{1'b0, 4'hF, 4'h0, 8'h11, 8'h22, 8'h33, 8'h44, 4'h4, 2'd2, 1'b1, 1'b0, 8'h22, 8'h22};
        vt[8]  = '{1'b0, 4'hF, 4'h0, 8'h11, 8'h22, 8'h33, 8'h44, 4'h0, 2'd2, 1'b0, 1'b1, 8'h33, 8'h22};
        vt[9]  = '{1'b0, 4'hF, 4'h0, 8'h11, 8'h22, 8'h33, 8'h44, 4'h8, 2'd3, 1'b1, 1'b0, 8'h33, 8'h33};
        vt[10] = '{1'b0, 4'hF, 4'h0, 8'h11, 8'h22, 8'h33, 8'h44, 4'h0, 2'd3, 1'b0, 1'b1, 8'h44, 8'h33};
        vt[11] = '{1'b0, 4'hF, 4'h0, 8'h11, 8'h22, 8'h33, 8'h44, 4'h1, 2'd0, 1'b1, 1'b0, 8'h44, 8'h44};
        vt[12] = '{1'b0, 4'h0, 4'h0, 8'h11, 8'h22, 8'h33, 8'h44, 4'h0, 2'd0, 1'b0, 1'b0, 8'h44, 8'h44};
        vt[13] = '{1'b0, 4'h3, 4'h0, 8'h11, 8'h22, 8'h33, 8'h44, 4'h2, 2'd1, 1'b1, 1'b0, 8'h44, 8'h44};
        vt[14] = '{1'b0, 4'h0, 4'h0, 8'h11, 8'h22, 8'h33, 8'h44, 4'h0, 2'd1, 1'b0, 1'b0, 8'h44, 8'h44};

        reset = 1'b1;
        req   = '0;
        lock  = '0;
        data  = '0;
        #12;
        chk("init_gnt",  32'(gnt),       32'h0);
        chk("init_qin",  32'(qin),       32'h0);
        chk("init_busy", 32'(busy),      32'h0);
        chk("init_wr",   32'(wr_strobe), 32'h0);
        chk("init_own",  32'(owner),     32'h0);
        reset = 1'b0;

        // Single beat, round-robin sweep, and owner abort.
        for (int i = 0; i < 15; i++) begin
            if (vt[i].rst) pulse_reset();
            req  = vt[i].req;
            lock = vt[i].lock;
            data = {vt[i].d3, vt[i].d2, vt[i].d1, vt[i].d0};
            @(posedge clk);
            #1;
            chk($sformatf("v%0d_gnt", i),  32'(gnt),       32'(vt[i].gnt));
            chk($sformatf("v%0d_own", i),  32'(owner),     32'(vt[i].own));
            chk($sformatf("v%0d_busy", i), 32'(busy),      32'(vt[i].busy));
            chk($sformatf("v%0d_wr", i),   32'(wr_strobe), 32'(vt[i].wr));
            chk($sformatf("v%0d_qin", i),  32'(qin),       32'(vt[i].qin));
            chk($sformatf("v%0d_rd", i),   32'(rd_data),   32'(vt[i].rd));
        end

        // Locked burst of requester 2 capped at 4 beats, requester 0 served before regrant.
        req  = 4'b0101;
        lock = 4'b0100;
        data = {8'h00, 8'h10, 8'h00, 8'hAA};
        cyc("lk_g", 4'b0100, 1'b1, 1'b0, 8'h44);
        for (int b = 0; b < 4; b++) begin
            cyc($sformatf("lk_b%0d", b), (b < 3) ? 4'b0100 : 4'b0000, b < 3, 1'b1, 8'(8'h10 + b));
            data[2] = 8'(8'h11 + b);
        end
        cyc("lk_r0", 4'b0001, 1'b1, 1'b0, 8'h13);
        chk("lk_r0_own", 32'(owner), 32'd0);
        cyc("lk_w0", 4'b0000, 1'b0, 1'b1, 8'hAA);
        req = 4'b0100;
        cyc("lk_rg", 4'b0100, 1'b1, 1'b0, 8'hAA);
        cyc("lk_b4", 4'b0100, 1'b1, 1'b1, 8'h14);
        data[2] = 8'h15;
        lock    = 4'b0000;
        cyc("lk_b5", 4'b0000, 1'b0, 1'b1, 8'h15);
        req = 4'b0000;
        cyc("lk_hold", 4'b0000, 1'b0, 1'b0, 8'h15);

        // Requester 1 waits out requester 3's locked burst.
        pulse_reset();
        req  = 4'b1000;
        lock = 4'b1000;
        data = {8'h50, 8'h00, 8'h77, 8'h00};
        cyc("ow_g3", 4'b1000, 1'b1, 1'b0, 8'h00);
        req = 4'b1010;
        for (int b = 0; b < 4; b++) begin
            cyc($sformatf("ow_b%0d", b), (b < 3) ? 4'b1000 : 4'b0000, b < 3, 1'b1, 8'(8'h50 + b));
            data[3] = 8'(8'h51 + b);
        end
        req  = 4'b0010;
        lock = 4'b0000;
        cyc("ow_g1", 4'b0010, 1'b1, 1'b0, 8'h53);
        chk("ow_g1_own", 32'(owner), 32'd1);
        cyc("ow_w1", 4'b0000, 1'b0, 1'b1, 8'h77);

        // Asynchronous reset in the middle of a burst.
        req  = 4'b0100;
        lock = 4'b0100;
        data = {8'h00, 8'h60, 8'h00, 8'h00};
        cyc("mr_g", 4'b0100, 1'b1, 1'b0, 8'h77);
        cyc("mr_b0", 4'b0100, 1'b1, 1'b1, 8'h60);
        #2;
        pulse_reset();
        chk("mr_qout", 32'(qout), 32'h0);
        req  = 4'b1111;
        lock = 4'b0000;
        cyc("mr_rg", 4'b0001, 1'b1, 1'b0, 8'h00);
        chk("mr_rg_own", 32'(owner), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/flop_load_arbiter.md
# flop_load_arbiter

Round-robin arbiter that shares the 8-bit `flipflop` register between several requesters. It grants ownership to one requester at a time and registers the owner's data onto the register's `qin` input. An owner may lock ownership for a bounded burst of beats. It sits between the requester agents and the `flipflop` instance, replacing the direct `qin` drive.

## Interface
Parameters:
- `N_REQ`, 4, number of requesters (2..8)
- `WIDTH`, 8, data width; matches the `flipflop` `qin`/`qout`
- `MAX_HOLD`, 4, maximum beats per ownership (1..15)

Ports:
- `clk`  in  1  single clock; all logic on posedge
- `reset`  in  1  asynchronous, active-high; clears all state immediately
- `req`  in  N_REQ  per-requester request; hold high with stable data until accepted
- `lock`  in  N_REQ  per-requester burst request; sampled on each accepted beat
- `data`  in  N_REQ x WIDTH  per-requester write data
- `qout`  in  WIDTH  current register value; passed through to `rd_data`
- `gnt`  out  N_REQ  one-hot ownership grant, registered
- `qin`  out  WIDTH  drives `flipflop.qin`, registered
- `wr_strobe`  out  1  one-cycle pulse: `qin` was updated at the last edge
- `busy`  out  1  ownership held (state OWN)
- `owner`  out  $clog2(N_REQ)  index of current/last owner
- `rd_data`  out  WIDTH  combinational copy of `qout`

## Operation
- States: IDLE, OWN.
- IDLE, any `req` high at an edge: pick winner w by round-robin, starting at `(last+1) mod N_REQ`.
  - Set `gnt[w]`, `owner<=w`, `busy<=1`, `beat<=0`, then go to OWN.
- IDLE, no `req`: stay; `gnt=0`.
- OWN, beat accepted at an edge where `req[owner] && gnt[owner]`:
  - `qin<=data[owner]`, `wr_strobe<=1`, `beat<=beat+1`.
  - Release if `lock[owner]==0` or `beat+1==MAX_HOLD`; otherwise stay in OWN.
- OWN, `req[owner]==0` at an edge (abort): release with no write.
- Release: `gnt<=0`, `busy<=0`, `last<=owner`, go to IDLE.
  - No re-arbitration on the release edge; one idle cycle always separates owners.
- Requests from non-owners are ignored while in OWN and are never queued; they are re-evaluated in IDLE.
- `qin` holds its value between writes, so the register keeps its content.
- `beat` is 4 bits and saturates by release; it never wraps.
- Reset values: `gnt=0`, `qin=0`, `wr_strobe=0`, `busy=0`, `owner=0`, `last=N_REQ-1`, so requester 0 wins first, state IDLE.
- Reset mid-burst: everything clears asynchronously; the partial burst is lost and `qin` returns to 0.

## Timing
- `req` seen at edge k -> `gnt` high after k -> beat accepted at k+1 -> `qin` valid after k+1 -> `qout` updated at k+2.
- Single-beat throughput: one write per 2 cycles, same or different requester.
- Locked burst: one write per cycle for up to `MAX_HOLD` beats.
  - The requester presents the next data in the cycle after each accepted edge.
- `wr_strobe` is high exactly in the cycle after each accepted edge.
- `lock` and `req` are sampled only at edges; no combinational path from inputs to `gnt`/`qin`.
  - `rd_data` is the only combinational output.

## Structure
- Package `flop_arb_pkg`:
  - `typedef enum logic {IDLE, OWN} arb_state_t`
  - default constants `ARB_N_REQ=4`, `ARB_WIDTH=8`, `ARB_MAX_HOLD=4`
- Sub-module `rr_priority_pick`: combinational; inputs `req` and `last`; outputs one-hot `win` and index `win_idx`, with `any`.
- Top contains the FSM, beat counter and output registers; it instantiates `flipflop` only in the bench.

## Test plan
- Reset, then `req=4'b0001`, `data[0]=8'h3C`, lock low -> `gnt=0001` after edge 1, `wr_strobe` after edge 2, `qout=8'h3C` after edge 3, `busy` falls after edge 2.
- `req=4'b1111` held, lock low, distinct data -> grants in order 0,1,2,3,0 with one idle cycle between each; `qin` follows `data[0..3]`.
- Requester 2 holds `lock=1` and `req=1` for 6 beats of data `8'h10..8'h15` -> first 4 beats written on consecutive cycles, then release; requester 2 regranted only after other pending requesters.
- Owner drops `req` in its `gnt` cycle -> no `wr_strobe`, `qin` unchanged, back to IDLE, `last` updated.
- `reset` asserted mid-burst between edges -> `gnt`, `qin`, `busy` go to 0 immediately; after release, requester 0 wins first.
- `req[1]` raised while requester 3 owns a locked burst -> no `gnt[1]` until requester 3 releases, then `gnt[1]` one cycle later.
